// File: rtl/store_buffer.sv
// Store buffer between MEM-stage load/store logic and a 64-bit data memory; loads own the port,
// stores drain whenever it is free. Store-to-load forwarding is enabled by defining SB_FORWARD_EN.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              St_Valid,
  input  logic [ADDR_W-1:0] St_Addr,
  input  logic [DATA_W-1:0] St_Data,
  output logic              St_Ready,
  input  logic              Ld_Valid,
  input  logic [ADDR_W-1:0] Ld_Addr,
  output logic [DATA_W-1:0] Ld_Data,
  output logic              Ld_Hit,
  output logic              Ld_Conflict,
  output logic              Empty,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] Read_Data
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;

  logic              conflict_raw;
  logic              hit_raw;
  logic [DATA_W-1:0] fwd_data;
  logic              load_grant;
  logic              drain;
  logic              push;

  // Scan oldest to youngest so the last exact match wins; ranges compared one bit wider so addr+7 never wraps.
  always_comb begin
    logic [PW-1:0]   idx;
    logic [ADDR_W:0] lo_e;
    logic [ADDR_W:0] lo_l;
    logic            ov;
    conflict_raw = 1'b0;
    hit_raw      = 1'b0;
    fwd_data     = '0;
    idx          = '0;
    lo_e         = '0;
    ov           = 1'b0;
    lo_l         = {1'b0, Ld_Addr};
    for (int k = 0; k < DEPTH; k++) begin
      idx  = head + PW'(k);
      lo_e = {1'b0, addr_q[idx]};
      ov   = (lo_e + (ADDR_W+1)'(7) >= lo_l) && (lo_l + (ADDR_W+1)'(7) >= lo_e);
      if ((PW+1)'(k) < count && ov) begin
`ifdef SB_FORWARD_EN
        if (addr_q[idx] == Ld_Addr) begin
          hit_raw  = 1'b1;
          fwd_data = data_q[idx];
        end else begin
          conflict_raw = 1'b1;
        end
`else
        conflict_raw = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    Ld_Conflict = Ld_Valid && conflict_raw;
    load_grant  = Ld_Valid && !Ld_Conflict;
    Ld_Hit      = load_grant && hit_raw;
    drain       = (count != '0) && !load_grant;
    St_Ready    = count < (PW+1)'(DEPTH);
    push        = St_Valid && St_Ready;
    Empty       = (count == '0);

    if (!Ld_Valid)   Ld_Data = '0;
    else if (Ld_Hit) Ld_Data = fwd_data;
    else             Ld_Data = Read_Data;

    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Mem_Addr   = '0;
    Write_Data = '0;
    if (load_grant) begin
      MemRead  = 1'b1;
      Mem_Addr = Ld_Addr;
    end else if (drain) begin
      MemWrite   = 1'b1;
      Mem_Addr   = addr_q[head];
      Write_Data = data_q[head];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)  tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset: count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= St_Addr;
      data_q[tail] <= St_Data;
    end
  end

endmodule
